// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: control + data payload with valid/ready,
// stall/flush, bubble insertion and an optional 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              Clock_i,
  input  logic              Reset_n_i,
  input  logic              Valid_i,
  output logic              Ready_o,
  input  logic [CTRL_W-1:0] Ctrl_i,
  input  logic [DATA_W-1:0] Data_i,
  input  logic              Stall_i,
  input  logic              Flush_i,
  output logic              Valid_o,
  input  logic              Ready_i,
  output logic [CTRL_W-1:0] Ctrl_o,
  output logic [DATA_W-1:0] Data_o,
  output logic [1:0]        Occupancy_o,
  output logic [15:0]       BubbleCount_o
);

  logic              m_valid_q, s_valid_q;
  logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
  logic [DATA_W-1:0] m_data_q, s_data_q;
  logic [15:0]       bubble_q;
  logic              ready;
  logic              in_x;
  logic              out_x;

  // With the skid buffer, ready depends only on registered skid state (gated by reset).
  always_comb begin
    out_x = m_valid_q & Ready_i & ~Stall_i;
    if (SKID != 0) begin
      ready = Reset_n_i & ~s_valid_q;
    end else begin
      ready = Reset_n_i & (~m_valid_q | (Ready_i & ~Stall_i));
    end
    in_x = Valid_i & ready;
  end

  always_ff @(posedge Clock_i) begin
    if (!Reset_n_i) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
      bubble_q  <= '0;
    end else begin
      if (!m_valid_q && (bubble_q != '1)) begin
        bubble_q <= bubble_q + 16'd1;
      end
      if (Flush_i) begin
        m_valid_q <= 1'b0;
        s_valid_q <= 1'b0;
        m_ctrl_q  <= '0;
      end else if (!m_valid_q || out_x) begin
        if (s_valid_q) begin
          m_valid_q <= 1'b1;
          m_ctrl_q  <= s_ctrl_q;
          m_data_q  <= s_data_q;
          if (in_x) begin
            s_valid_q <= 1'b1;
            s_ctrl_q  <= Ctrl_i;
            s_data_q  <= Data_i;
          end else begin
            s_valid_q <= 1'b0;
          end
        end else if (in_x) begin
          m_valid_q <= 1'b1;
          m_ctrl_q  <= Ctrl_i;
          m_data_q  <= Data_i;
        end else begin
          // Bubble: control cleared, data left holding its last value.
          m_valid_q <= 1'b0;
          m_ctrl_q  <= '0;
        end
      end else if (in_x && (SKID != 0)) begin
        s_valid_q <= 1'b1;
        s_ctrl_q  <= Ctrl_i;
        s_data_q  <= Data_i;
      end
    end
  end

  assign Ready_o       = ready;
  assign Valid_o       = m_valid_q;
  assign Ctrl_o        = m_ctrl_q;
  assign Data_o        = m_data_q;
  assign Occupancy_o   = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign BubbleCount_o = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance (SKID=1) and a single-entry instance (SKID=0).
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  int            checks = 0;
  int            failures = 0;

  logic          a_valid_i, a_ready_o, a_stall, a_flush, a_valid_o, a_ready_i;
  logic [CW-1:0] a_ctrl_i, a_ctrl_o;
  logic [DW-1:0] a_data_i, a_data_o;
  logic [1:0]    a_occ;
  logic [15:0]   a_bub;

  logic          b_valid_i, b_ready_o, b_stall, b_flush, b_valid_o, b_ready_i;
  logic [CW-1:0] b_ctrl_i, b_ctrl_o;
  logic [DW-1:0] b_data_i, b_data_o;
  logic [1:0]    b_occ;
  logic [15:0]   b_bub;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_a (
    .Clock_i(clk), .Reset_n_i(rst_n), .Valid_i(a_valid_i), .Ready_o(a_ready_o),
    .Ctrl_i(a_ctrl_i), .Data_i(a_data_i), .Stall_i(a_stall), .Flush_i(a_flush),
    .Valid_o(a_valid_o), .Ready_i(a_ready_i), .Ctrl_o(a_ctrl_o), .Data_o(a_data_o),
    .Occupancy_o(a_occ), .BubbleCount_o(a_bub)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_b (
    .Clock_i(clk), .Reset_n_i(rst_n), .Valid_i(b_valid_i), .Ready_o(b_ready_o),
    .Ctrl_i(b_ctrl_i), .Data_i(b_data_i), .Stall_i(b_stall), .Flush_i(b_flush),
    .Valid_o(b_valid_o), .Ready_i(b_ready_i), .Ctrl_o(b_ctrl_o), .Data_o(b_data_o),
    .Occupancy_o(b_occ), .BubbleCount_o(b_bub)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid_i = 0; a_ready_i = 1; a_stall = 0; a_flush = 0; a_ctrl_i = '0; a_data_i = '0;
    b_valid_i = 0; b_ready_i = 1; b_stall = 0; b_flush = 0; b_ctrl_i = '0; b_data_i = '0;
    #1;
    chk("rst_ready_low", 32'(a_ready_o), 32'd0);
    step(); step();
    chk("rst_valid", 32'(a_valid_o), 32'd0);
    chk("rst_ctrl", 32'(a_ctrl_o), 32'd0);
    chk("rst_data", 32'(a_data_o), 32'd0);
    chk("rst_occ", 32'(a_occ), 32'd0);
    chk("rst_bub", 32'(a_bub), 32'd0);
    chk("rst_ready_during", 32'(a_ready_o), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(a_ready_o), 32'd1);

    // Streaming 1..4 with downstream always ready
    a_valid_i = 1;
    for (int i = 1; i <= 4; i++) begin
      a_data_i = DW'(i);
      a_ctrl_i = CW'(8'h10 + i);
      step();
      chk("stream_valid", 32'(a_valid_o), 32'd1);
      chk("stream_data", 32'(a_data_o), 32'(i));
      chk("stream_ctrl", 32'(a_ctrl_o), 32'(8'h10 + i));
      chk("stream_ready", 32'(a_ready_o), 32'd1);
      chk("stream_bub", 32'(a_bub), 32'd1);
    end
    a_valid_i = 0;
    step();
    chk("drain_valid", 32'(a_valid_o), 32'd0);
    chk("drain_ctrl_zero", 32'(a_ctrl_o), 32'd0);
    chk("drain_data_hold", 32'(a_data_o), 32'd4);
    chk("drain_bub", 32'(a_bub), 32'd1);
    step();
    chk("idle_bub", 32'(a_bub), 32'd2);

    // Stall with skid: A in M, B absorbed into S, C refused until release
    a_valid_i = 1; a_data_i = 16'h000A; a_ctrl_i = 8'hA0;
    step();
    chk("stall_m_a", 32'(a_data_o), 32'hA);
    chk("stall_bub", 32'(a_bub), 32'd3);
    a_stall = 1; a_data_i = 16'h000B; a_ctrl_i = 8'hB0;
    #1;
    chk("stall_ready_pre", 32'(a_ready_o), 32'd1);
    step();
    chk("stall_occ2", 32'(a_occ), 32'd2);
    chk("stall_ready0", 32'(a_ready_o), 32'd0);
    chk("stall_hold_a", 32'(a_data_o), 32'hA);
    a_data_i = 16'h000C; a_ctrl_i = 8'hC0;
    step(); step();
    chk("stall_hold_a2", 32'(a_data_o), 32'hA);
    chk("stall_hold_ctrl", 32'(a_ctrl_o), 32'hA0);
    chk("stall_occ2b", 32'(a_occ), 32'd2);
    a_stall = 0;
    #1;
    chk("release_ready_reg", 32'(a_ready_o), 32'd0);
    step();
    chk("release_b", 32'(a_data_o), 32'hB);
    chk("release_occ1", 32'(a_occ), 32'd1);
    chk("release_ready1", 32'(a_ready_o), 32'd1);
    step();
    chk("release_c", 32'(a_data_o), 32'hC);
    chk("release_c_ctrl", 32'(a_ctrl_o), 32'hC0);
    a_valid_i = 0;
    step();
    chk("release_empty", 32'(a_valid_o), 32'd0);
    chk("release_occ0", 32'(a_occ), 32'd0);
    chk("release_bub", 32'(a_bub), 32'd3);

    // Flush with occupancy 2, combined with stall and an offered beat
    a_ready_i = 0; a_valid_i = 1; a_data_i = 16'h005A; a_ctrl_i = 8'h5A;
    step();
    a_data_i = 16'h005B; a_ctrl_i = 8'h5B;
    step();
    chk("pre_flush_occ", 32'(a_occ), 32'd2);
    chk("pre_flush_ctrl", 32'(a_ctrl_o), 32'h5A);
    a_flush = 1; a_stall = 1; a_data_i = 16'h0077; a_ctrl_i = 8'h77;
    step();
    chk("flush_valid", 32'(a_valid_o), 32'd0);
    chk("flush_ctrl", 32'(a_ctrl_o), 32'd0);
    chk("flush_occ", 32'(a_occ), 32'd0);
    chk("flush_ready", 32'(a_ready_o), 32'd1);
    chk("flush_data_hold", 32'(a_data_o), 32'h5A);
    chk("flush_bub", 32'(a_bub), 32'd4);
    step();
    chk("flush_drop_in", 32'(a_valid_o), 32'd0);
    chk("flush_drop_occ", 32'(a_occ), 32'd0);
    chk("flush_bub_counts", 32'(a_bub), 32'd5);
    a_flush = 0; a_stall = 0; a_valid_i = 0;

    // Reset mid-operation with occupancy 2
    a_valid_i = 1; a_data_i = 16'h0031; a_ctrl_i = 8'h31;
    step();
    a_data_i = 16'h0032; a_ctrl_i = 8'h32;
    step();
    chk("pre_rst_occ", 32'(a_occ), 32'd2);
    rst_n = 0; a_ready_i = 1; a_data_i = 16'h0033; a_ctrl_i = 8'h33;
    #1;
    chk("mid_rst_ready", 32'(a_ready_o), 32'd0);
    step();
    chk("mid_rst_valid", 32'(a_valid_o), 32'd0);
    chk("mid_rst_data", 32'(a_data_o), 32'd0);
    chk("mid_rst_ctrl", 32'(a_ctrl_o), 32'd0);
    chk("mid_rst_occ", 32'(a_occ), 32'd0);
    chk("mid_rst_bub", 32'(a_bub), 32'd0);
    rst_n = 1; a_data_i = 16'h0044; a_ctrl_i = 8'h44;
    #1;
    chk("post_rst_ready", 32'(a_ready_o), 32'd1);
    step();
    chk("post_rst_valid", 32'(a_valid_o), 32'd1);
    chk("post_rst_data", 32'(a_data_o), 32'h44);
    chk("post_rst_bub", 32'(a_bub), 32'd1);
    a_valid_i = 0;
    step();
    chk("sat_start", 32'(a_bub), 32'd1);

    // Bubble counter saturation
    repeat (65533) step();
    chk("sat_fffe", 32'(a_bub), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(a_bub), 32'hFFFF);
    repeat (3) step();
    chk("sat_hold", 32'(a_bub), 32'hFFFF);

    // SKID=0: combinational back-pressure and replace-in-place
    b_valid_i = 1; b_ready_i = 1; b_data_i = 16'h0021; b_ctrl_i = 8'h21;
    #1;
    chk("b_ready_empty", 32'(b_ready_o), 32'd1);
    step();
    chk("b_data21", 32'(b_data_o), 32'h21);
    chk("b_valid", 32'(b_valid_o), 32'd1);
    b_ready_i = 0; b_data_i = 16'h0022; b_ctrl_i = 8'h22;
    #1;
    chk("b_ready_bp", 32'(b_ready_o), 32'd0);
    step();
    chk("b_hold21", 32'(b_data_o), 32'h21);
    chk("b_occ1", 32'(b_occ), 32'd1);
    b_ready_i = 1;
    #1;
    chk("b_ready_comb", 32'(b_ready_o), 32'd1);
    step();
    chk("b_data22", 32'(b_data_o), 32'h22);
    chk("b_ctrl22", 32'(b_ctrl_o), 32'h22);
    b_data_i = 16'h0023; b_ctrl_i = 8'h23;
    step();
    chk("b_data23", 32'(b_data_o), 32'h23);
    chk("b_occ_max1", 32'(b_occ), 32'd1);
    b_stall = 1;
    #1;
    chk("b_ready_stall", 32'(b_ready_o), 32'd0);
    b_stall = 0; b_valid_i = 0;
    step();
    chk("b_empty", 32'(b_valid_o), 32'd0);
    chk("b_ctrl_zero", 32'(b_ctrl_o), 32'd0);
    chk("b_data_hold", 32'(b_data_o), 32'h23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
